bsg_tag_packet_rx: RTL and testbench
====================================

# bsg_tag_packet_rx

Serial-to-parallel receiver for the bsg_tag single-bit packet line; it is the far end of the tag-stream generator that serializes trace-replay packets. It watches the tag bit stream, detects start bits, parses the header (nodeID, data_not_reset, length), collects exactly `length` payload bits and presents each completed packet as one parallel word on a valid/ready port. It is used as a scoreboard front-end in tag testbenches and as a bus monitor beside real bsg_tag masters.

## Interface
- num_clients_p, none (must be set), number of tag clients; N = `BSG_SAFE_CLOG2(num_clients_p)
- max_payload_width_p, none (must be set), max payload D; L = `BSG_SAFE_CLOG2(D+1); header width H = N+1+L
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- tag_v_i  in  1  serial bit valid
- tag_data_i  in  1  serial tag bit
- tag_yumi_o  out  1  serial bit consumed this cycle
- v_o  out  1  parallel packet valid
- node_id_o  out  N  packet nodeID
- data_not_reset_o  out  1  0 = client reset packet
- len_o  out  L  payload length in bits
- payload_o  out  D  payload, LSB = first payload bit, bits ≥ len_o zero
- ready_and_i  in  1  consumer ready; transfer when v_o & ready_and_i
- error_o  out  1  sticky length error

## Operation
- Serial order, LSB first: start bit 1; len[0..L-1]; data_not_reset; nodeID[0..N-1]; payload[0..len-1]. Header packs MSB→LSB as {nodeID, data_not_reset, len}.
- A bit is consumed when tag_yumi_o = tag_v_i & ~stall. Cycles with tag_v_i=0 are ignored and do not advance state.
- FSM:
  - IDLE: consumed 0 stays IDLE (idle and padding zeros); consumed 1 → HDR, bit counter cleared.
  - HDR: shift H bits into the header register. After the last header bit: len=0 → completes packet, return to IDLE; otherwise → PAY.
  - PAY: shift bits into payload position counter; after bit index len-1, complete packet, → IDLE.
- Completion loads the output register {node_id, dnr, len, payload} and sets v_o. Payload bits above len are zero.
- Zeros the generator pads after `len` (up to D) are treated as IDLE. A 1 in that region is a new start bit; stream authors must zero-pad.
- Stall: the bit that would complete a packet is not consumed (tag_yumi_o=0) while v_o=1 and ready_and_i=0. Non-completing bits are never stalled.
- Simultaneous dequeue and completion in the same cycle: the old packet transfers and the new one loads; v_o stays 1.
- Reset mid-packet: the partial packet is discarded and the FSM goes to IDLE.

## Timing
- Reset values: v_o=0, error_o=0, tag_yumi_o=0 (combinational, state IDLE), node_id_o/data_not_reset_o/len_o/payload_o=0.
- v_o rises the cycle after the completing bit is consumed. Minimum latency start→v_o is 1+H+len consumed bits plus 1 cycle.
- Throughput is one bit per cycle. Back-to-back packets need no gap bits.
- Outputs hold stable while v_o & ~ready_and_i.

## Configuration
- BSG_TAG_PACKET_RX_LEN_CHECK_EN defined:
  - A header with len > max_payload_width_p sets error_o, which stays set until reset.
  - That packet is not emitted. The FSM returns to IDLE immediately after the header.
- Undefined:
  - error_o is tied 0.
  - len is clamped to max_payload_width_p for bit counting.
  - len_o reports the clamped value.

## Structure
- The header struct macro (`declare_bsg_tag_header_s`) and the width localparams (N, L, H) belong in the shared bsg_tag package/header, shared with the transmitter side.
- One sub-module: bsg_counter_clear_up (bit counter, width `BSG_SAFE_CLOG2(max(H,D))`).
- The output register is a bsg_dff_reset_en.

## Test plan
All scenarios use num_clients_p=4 (N=2), max_payload_width_p=8 (L=4), H=7.
- Stream 1,1,0,1,0,1,0,1,1,0,1,0,1 → one v_o: node 2, dnr 1, len 5, payload 0x15, 1 cycle after the 13th consumed bit.
- Client reset packet: node 3, dnr 0, len 8, payload 0xFF → emitted with data_not_reset_o=0, payload 0xFF.
- len=0 packet (node 1) → v_o after 8 bits, payload 0. The next packet's start bit immediately follows and is parsed correctly.
- Hold ready_and_i=0 with one packet pending while a second arrives → tag_yumi_o=0 only on its final bit. On ready_and_i=1, packet 1 transfers, packet 2 loads the same cycle, and v_o stays 1.
- With LEN_CHECK_EN, header len=9 → error_o=1 sticky, no v_o. With the macro off, len_o=8 and error_o=0.
- Assert reset_i after 4 header bits, then send a valid packet → only the valid packet is emitted, with correct fields.

Source files
------------

// File: rtl/bsg_tag_packet_rx_pkg.sv
// Shared bsg_tag definitions: header struct macro, width helpers, FSM states.
// Optional length checking is enabled by BSG_TAG_PACKET_RX_LEN_CHECK_EN.
`ifndef BSG_TAG_PACKET_RX_PKG_SV
`define BSG_TAG_PACKET_RX_PKG_SV

`define BSG_DECLARE_TAG_HEADER_S(n_mp, l_mp) \
    typedef struct packed { \
        logic [(n_mp)-1:0] node_id; \
        logic data_not_reset; \
        logic [(l_mp)-1:0] len; \
    } bsg_tag_header_s

package bsg_tag_packet_rx_pkg;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_HDR  = 2'd1,
        RX_PAY  = 2'd2
    } rx_state_e;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    function automatic int tag_node_w(input int num_clients);
        return safe_clog2(num_clients);
    endfunction

    function automatic int tag_len_w(input int max_payload);
        return safe_clog2(max_payload + 1);
    endfunction

    function automatic int tag_hdr_w(input int num_clients, input int max_payload);
        return tag_node_w(num_clients) + 1 + tag_len_w(max_payload);
    endfunction

endpackage

`endif

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear wins over increment.
module bsg_counter_clear_up #(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (up_i) begin
            count_d = count_q + width_p'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bsg_dff_reset_en.sv
// Register with synchronous reset to zero and load enable.
module bsg_dff_reset_en #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_tag_packet_rx.sv
// Serial bsg_tag packet receiver presenting parsed packets on a valid/ready port.
// Define BSG_TAG_PACKET_RX_LEN_CHECK_EN to flag and drop over-length headers.
module bsg_tag_packet_rx
    import bsg_tag_packet_rx_pkg::*;
#(
    parameter int num_clients_p       = 4,
    parameter int max_payload_width_p = 8,
    localparam int N = tag_node_w(num_clients_p),
    localparam int L = tag_len_w(max_payload_width_p),
    localparam int D = max_payload_width_p
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         tag_v_i,
    input  logic         tag_data_i,
    output logic         tag_yumi_o,
    output logic         v_o,
    output logic [N-1:0] node_id_o,
    output logic         data_not_reset_o,
    output logic [L-1:0] len_o,
    output logic [D-1:0] payload_o,
    input  logic         ready_and_i,
    output logic         error_o
);

    localparam int H = N + 1 + L;
    localparam int C = safe_clog2((H > D) ? H : D);
    localparam logic [L-1:0] max_len_lp = L'(D);
    localparam logic [C-1:0] hdr_last_lp = C'(H - 1);

    `BSG_DECLARE_TAG_HEADER_S(N, L);

    rx_state_e state_q, state_d;
    logic [H-1:0] hdr_q, hdr_d;
    logic [D-1:0] pay_q, pay_d;
    logic v_q, v_d;

    logic [C-1:0] cnt;
    logic cnt_clr, cnt_up;
    logic take, complete, emit, stall;
    logic [H-1:0] hdr_full;
    bsg_tag_header_s hdr_s;
    logic [L-1:0] len_raw, len_eff;
    logic len_bad, hdr_err;
    logic [C-1:0] pay_last;
    logic [D-1:0] pay_next;
    logic [H+D-1:0] out_q;
    bsg_tag_header_s out_hdr;

    // Header bits arrive LSB first, so shift in from the top.
    always_comb begin
        hdr_full = {tag_data_i, hdr_q[H-1:1]};
        len_raw  = hdr_full[L-1:0];
        len_bad  = (len_raw > max_len_lp);
        len_eff  = len_bad ? max_len_lp : len_raw;
        hdr_s     = bsg_tag_header_s'(hdr_full);
        hdr_s.len = len_eff;
`ifdef BSG_TAG_PACKET_RX_LEN_CHECK_EN
        hdr_err = len_bad;
`else
        hdr_err = 1'b0;
`endif
        pay_last = C'(hdr_q[L-1:0] - L'(1));
        pay_next = pay_q;
        for (int i = 0; i < D; i++) begin
            if (cnt == C'(i)) begin
                pay_next[i] = tag_data_i;
            end
        end
    end

    always_comb begin
        complete = 1'b0;
        unique case (state_q)
            RX_HDR:  complete = (cnt == hdr_last_lp) & ~hdr_err & (len_eff == '0);
            RX_PAY:  complete = (cnt == pay_last);
            default: complete = 1'b0;
        endcase
        stall = complete & v_q & ~ready_and_i;
        take  = tag_v_i & ~stall;
        emit  = take & complete;
        v_d   = emit | (v_q & ~ready_and_i);
    end

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        pay_d   = pay_q;
        cnt_clr = 1'b0;
        cnt_up  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (take & tag_data_i) begin
                    state_d = RX_HDR;
                    cnt_clr = 1'b1;
                    pay_d   = '0;
                end
            end
            RX_HDR: begin
                if (take) begin
                    cnt_up = 1'b1;
                    hdr_d  = hdr_full;
                    if (cnt == hdr_last_lp) begin
                        hdr_d   = H'(hdr_s);
                        cnt_clr = 1'b1;
                        if (hdr_err || len_eff == '0) begin
                            state_d = RX_IDLE;
                        end else begin
                            state_d = RX_PAY;
                        end
                    end
                end
            end
            RX_PAY: begin
                if (take) begin
                    cnt_up = 1'b1;
                    pay_d  = pay_next;
                    if (complete) begin
                        cnt_clr = 1'b1;
                        state_d = RX_IDLE;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= RX_IDLE;
            hdr_q   <= '0;
            pay_q   <= '0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            pay_q   <= pay_d;
            v_q     <= v_d;
        end
    end

`ifdef BSG_TAG_PACKET_RX_LEN_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == RX_HDR && take && cnt == hdr_last_lp && hdr_err) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

    bsg_counter_clear_up #(
        .width_p(C)
    ) bit_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(cnt_clr),
        .up_i   (cnt_up),
        .count_o(cnt)
    );

    // On completion the next-state header/payload is exactly the packet word.
    bsg_dff_reset_en #(
        .width_p(H + D)
    ) out_reg (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en_i   (emit),
        .data_i ({hdr_d, pay_d}),
        .data_o (out_q)
    );

    assign out_hdr          = bsg_tag_header_s'(out_q[H+D-1:D]);
    assign node_id_o        = out_hdr.node_id;
    assign data_not_reset_o = out_hdr.data_not_reset;
    assign len_o            = out_hdr.len;
    assign payload_o        = out_q[D-1:0];
    assign v_o              = v_q;
    assign tag_yumi_o       = take;

endmodule

// File: tb/tb_bsg_tag_packet_rx.sv
// Directed bench for bsg_tag_packet_rx with num_clients_p=4, max_payload_width_p=8.
module tb_bsg_tag_packet_rx;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       tag_v_i;
    logic       tag_data_i;
    logic       tag_yumi_o;
    logic       v_o;
    logic [1:0] node_id_o;
    logic       data_not_reset_o;
    logic [3:0] len_o;
    logic [7:0] payload_o;
    logic       ready_and_i;
    logic       error_o;

    int vectors = 0;
    int miscompares = 0;
    int drops = 0;

    always #5 clk = ~clk;

    bsg_tag_packet_rx #(
        .num_clients_p      (4),
        .max_payload_width_p(8)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .tag_v_i         (tag_v_i),
        .tag_data_i      (tag_data_i),
        .tag_yumi_o      (tag_yumi_o),
        .v_o             (v_o),
        .node_id_o       (node_id_o),
        .data_not_reset_o(data_not_reset_o),
        .len_o           (len_o),
        .payload_o       (payload_o),
        .ready_and_i     (ready_and_i),
        .error_o         (error_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        tag_v_i    = 1'b1;
        tag_data_i = b;
        #1;
        if (tag_yumi_o !== 1'b1) drops++;
        @(posedge clk);
        #1;
        tag_v_i    = 1'b0;
        tag_data_i = 1'b0;
    endtask

    task automatic send_pkt(input string tag, input logic [1:0] node, input logic dnr,
                            input logic [3:0] len, input logic [7:0] pay, input int plen);
        drops = 0;
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_bit(len[i]);
        send_bit(dnr);
        for (int i = 0; i < 2; i++) send_bit(node[i]);
        for (int i = 0; i < plen; i++) send_bit(pay[i]);
        chk({tag, ".consumed"}, drops, 0);
    endtask

    task automatic chk_pkt(input string tag, input logic [1:0] node, input logic dnr,
                           input logic [3:0] len, input logic [7:0] pay);
        chk({tag, ".v"}, v_o, 1);
        chk({tag, ".node"}, node_id_o, node);
        chk({tag, ".dnr"}, data_not_reset_o, dnr);
        chk({tag, ".len"}, len_o, len);
        chk({tag, ".payload"}, payload_o, pay);
    endtask

    task automatic deq(input string tag);
        ready_and_i = 1'b1;
        step();
        ready_and_i = 1'b0;
        chk({tag, ".deq"}, v_o, 0);
    endtask

    int s1[13] = '{1, 1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 1};
    int b2[9]  = '{1, 1, 0, 0, 0, 1, 0, 1, 1};

    initial begin
        reset_i     = 1'b1;
        tag_v_i     = 1'b0;
        tag_data_i  = 1'b0;
        ready_and_i = 1'b0;
        step();
        step();
        chk("rst.v", v_o, 0);
        chk("rst.err", error_o, 0);
        chk("rst.yumi", tag_yumi_o, 0);
        chk("rst.node", node_id_o, 0);
        chk("rst.dnr", data_not_reset_o, 0);
        chk("rst.len", len_o, 0);
        chk("rst.payload", payload_o, 0);
        reset_i = 1'b0;
        step();

        // Stream from the test plan: node 2, dnr 1, len 5, payload 0x15
        drops = 0;
        for (int i = 0; i < 12; i++) send_bit(s1[i][0]);
        chk("s1.early_v", v_o, 0);
        send_bit(s1[12][0]);
        chk("s1.consumed", drops, 0);
        chk_pkt("s1", 2'd2, 1'b1, 4'd5, 8'h15);
        step();
        chk("s1.hold_payload", payload_o, 8'h15);
        deq("s1");

        // Client reset packet
        send_pkt("crst", 2'd3, 1'b0, 4'd8, 8'hFF, 8);
        chk_pkt("crst", 2'd3, 1'b0, 4'd8, 8'hFF);
        deq("crst");

        // len=0 packet, then a back-to-back packet with no gap bits
        send_pkt("len0", 2'd1, 1'b1, 4'd0, 8'h00, 0);
        chk_pkt("len0", 2'd1, 1'b1, 4'd0, 8'h00);
        ready_and_i = 1'b1;
        drops = 0;
        send_bit(1'b1);
        chk("b2b.deq", v_o, 0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        ready_and_i = 1'b0;
        chk("b2b.consumed", drops, 0);
        chk_pkt("b2b", 2'd0, 1'b1, 4'd3, 8'h05);
        deq("b2b");

        // Stall: second packet's final bit waits for the consumer
        send_pkt("stA", 2'd1, 1'b1, 4'd2, 8'h03, 2);
        chk_pkt("stA", 2'd1, 1'b1, 4'd2, 8'h03);
        drops = 0;
        for (int i = 0; i < 8; i++) send_bit(b2[i][0]);
        chk("stB.consumed", drops, 0);
        tag_v_i    = 1'b1;
        tag_data_i = b2[8][0];
        #1;
        chk("stB.stall_yumi", tag_yumi_o, 0);
        step();
        chk("stB.hold_v", v_o, 1);
        chk("stB.hold_node", node_id_o, 2'd1);
        chk("stB.hold_len", len_o, 4'd2);
        chk("stB.stall_yumi2", tag_yumi_o, 0);
        ready_and_i = 1'b1;
        #1;
        chk("stB.release_yumi", tag_yumi_o, 1);
        step();
        tag_v_i     = 1'b0;
        tag_data_i  = 1'b0;
        ready_and_i = 1'b0;
        chk_pkt("stB", 2'd2, 1'b1, 4'd1, 8'h01);
        deq("stB");

        // Over-length header (len=9)
`ifdef BSG_TAG_PACKET_RX_LEN_CHECK_EN
        send_pkt("big", 2'd0, 1'b1, 4'd9, 8'h00, 0);
        chk("big.err", error_o, 1);
        chk("big.v", v_o, 0);
        send_bit(1'b0);
        step();
        chk("big.err_sticky", error_o, 1);
        chk("big.v2", v_o, 0);
`else
        send_pkt("big", 2'd0, 1'b1, 4'd9, 8'hA5, 8);
        chk_pkt("big", 2'd0, 1'b1, 4'd8, 8'hA5);
        chk("big.err", error_o, 0);
        deq("big");
`endif

        // Reset mid-header, then a clean packet
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        chk("mid.v", v_o, 0);
        chk("mid.err", error_o, 0);
        send_pkt("mid", 2'd2, 1'b1, 4'd4, 8'h09, 4);
        chk_pkt("mid", 2'd2, 1'b1, 4'd4, 8'h09);
        deq("mid");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
